fifo_reader: RTL
================

// Module: fifo_reader
// PURPOSE
//  Drain-side controller for the synchronous FIFO (registered data_out, 1-cycle read latency).
//  Issues fifo_rd_en only when the FIFO is non-empty and a buffer slot is free.
//  Re-times the popped words onto a valid/ready stream (m_*) for the downstream pipeline stage.
//  Supports a flush command that discards buffered words and empties the FIFO.
// PARAMETERS
//  WORD_SIZE  32  data width; must match the FIFO word_size
//  CNT_W      16  width of the delivered-word and discarded-word counters
// PORTS
//  clk            in   1          clock; all state updates on posedge
//  reset          in   1          synchronous, active-high
//  fifo_empty     in   1          FIFO empty flag, registered, reflects state after the last edge
//  fifo_rd_en     out  1          pop request to FIFO (combinational from state and fifo_empty)
//  fifo_rd_data   in   WORD_SIZE  FIFO data_out; valid in the cycle after a fifo_rd_en cycle
//  m_valid        out  1          output word valid (registered)
//  m_ready        in   1          downstream accepts when m_valid && m_ready
//  m_data         out  WORD_SIZE  output word = head of buffer (registered)
//  flush          in   1          1-cycle pulse: discard all pending and FIFO-resident words
//  busy           out  1          occupancy!=0 || inflight || state==FLUSH
//  words_out      out  CNT_W      count of m_valid&&m_ready handshakes, wraps mod 2^CNT_W
//  words_dropped  out  CNT_W      count of words discarded by flush, wraps
// BEHAVIOUR
//  Reset: state=RUN, occ=0, inflight=0, m_valid=0, m_data=0, counters=0, fifo_rd_en=0.
//  Reset mid-operation: in-flight FIFO data is ignored; reset has priority over flush.
//  State: occ (0..2, 2-entry buffer), inflight (read issued last cycle), FSM {RUN, FLUSH}.
//  RUN issue rule: fifo_rd_en = !fifo_empty && (occ + inflight - (m_valid&&m_ready)) < 2.
//  Capture: if inflight is high at an edge, fifo_rd_data is written to the buffer tail.
//  Latency: fifo_rd_en in cycle t -> word in buffer after edge t+1 -> m_valid in cycle t+2.
//  Throughput: 1 word/cycle sustained while m_ready=1 and the FIFO is non-empty.
//  Backpressure: m_ready=0 holds m_valid and m_data stable. Max 2 words held plus 0 inflight;
//    no pop is issued that cannot be stored. The FIFO is never read while empty.
//  Simultaneous capture and pop: occ unchanged; entry 1 shifts to head; new word becomes tail,
//    or head if occ was 1.
//  Order: words are delivered strictly in pop order; none are lost or duplicated.
//  flush in RUN:
//    - next edge: occ=0, m_valid=0, state=FLUSH.
//    - If m_valid&&m_ready in the same cycle as flush, that handshake completes and counts
//      in words_out, not words_dropped.
//    - Discarded buffered words add to words_dropped.
//  FLUSH:
//    - fifo_rd_en = !fifo_empty, without the slot check.
//    - Every landed inflight word is discarded (words_dropped+1). m_valid stays 0.
//    - Exit to RUN at the edge where fifo_empty==1 && inflight==0 && fifo_rd_en==0.
//    - flush asserted in FLUSH is ignored.
//  Counters: plain CNT_W-bit adders; they wrap from all-ones to 0 with no saturation.
// STRUCTURE
//  Shared header processor_defs.vh: WORD_SIZE default, FSM state encodings (RUN=0, FLUSH=1).
//  One sub-module: fifo_reader_buf, a 2-entry shift buffer.
//    - Ports: push, pop, clear, din -> dout, occ.
//    - Parent holds the FSM, issue logic, inflight flag and counters.
// TESTING (bench pairs with the real fifo module, fifo_size=20)
//  1. Write 0x11,0x22,0x33, m_ready=1 -> rd_en at t0..t2, m_data 0x11,0x22,0x33 at t2..t4,
//     words_out=3.
//  2. Preload 8 words, m_ready=0 -> exactly 2 pops, then rd_en=0 with occ=2 and m_data stable.
//     Release m_ready -> all 8 delivered in order, 1 per cycle.
//  3. FIFO empty, m_ready toggling -> fifo_rd_en never 1, m_valid stays 0, busy=0.
//  4. Preload 10, hold m_ready=0, pulse flush -> m_valid=0 next cycle, FIFO drained to empty,
//     words_dropped=10, state returns to RUN, busy=0.
//  5. Flush in the same cycle as a handshake of 0xA5 -> words_out+1, remaining words dropped.
//  6. Reset asserted with occ=2 and inflight=1 -> next cycle all outputs at reset values;
//     stale fifo_rd_data never appears on m_data.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO drain-side reader.
//   WORD_SIZE_DEF / CNT_W_DEF : default data and counter widths
//   ST_RUN / ST_FLUSH         : reader FSM encodings
//   pending_words()           : words held or in flight after this cycle's handshake
package fifo_reader_pkg;

    localparam int unsigned WORD_SIZE_DEF = 32;
    localparam int unsigned CNT_W_DEF     = 16;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [2:0] BUF_SLOTS = 3'd2;

    // A handshake implies occ >= 1, so the subtraction never underflows.
    function automatic logic [2:0] pending_words(input logic [1:0] occ,
                                                 input logic       inflight,
                                                 input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry shift buffer holding words popped from the FIFO.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write din at the tail
//   pop        : remove the head
//   clear      : discard all entries (wins over push/pop)
//   dout       : head entry (registered)
//   occ        : number of valid entries, 0..2
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] din,
    output logic [WORD_SIZE-1:0] dout,
    output logic [1:0]           occ
);

    logic [WORD_SIZE-1:0] head_q, head_d;
    logic [WORD_SIZE-1:0] tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = din;
                    else               tail_d = din;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    // Head only moves when a second entry exists to replace it.
                    if (occ_q == 2'd2) head_d = tail_q;
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = din;
                    end else begin
                        head_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drain-side controller for a synchronous FIFO with 1-cycle read latency. Pops only when a
// buffer slot is guaranteed, re-times words onto a valid/ready stream, and supports flush.
//   clk, reset          : clock, synchronous active-high reset
//   fifo_empty          : FIFO empty flag (registered)
//   fifo_rd_en          : pop request to the FIFO
//   fifo_rd_data        : FIFO data, valid the cycle after fifo_rd_en
//   m_valid/m_ready     : output stream handshake
//   m_data              : output word (head of buffer)
//   flush               : discard buffered, in-flight and FIFO-resident words
//   busy                : words held, read in flight, or flush in progress
//   words_out           : delivered-word count (wraps)
//   words_dropped       : flushed-word count (wraps)
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [WORD_SIZE-1:0] fifo_rd_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    input  logic                 flush,
    output logic                 busy,
    output logic [CNT_W-1:0]     words_out,
    output logic [CNT_W-1:0]     words_dropped
);

    logic [0:0]       state_q, state_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [1:0] occ;
    logic       hs;
    logic       push;
    logic       clear;
    logic       rd_req;

    fifo_reader_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (hs),
        .clear (clear),
        .din   (fifo_rd_data),
        .dout  (m_data),
        .occ   (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign hs      = m_valid && m_ready;

    always_comb begin
        state_d    = state_q;
        rd_req     = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        out_cnt_d  = out_cnt_q + CNT_W'(hs);
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            ST_RUN: begin
                rd_req = !fifo_empty && (pending_words(occ, inflight_q, hs) < BUF_SLOTS);
                if (flush) begin
                    // A same-cycle handshake still delivers; everything else held is dropped,
                    // including a word landing at this edge.
                    clear      = 1'b1;
                    state_d    = ST_FLUSH;
                    drop_cnt_d = drop_cnt_q + CNT_W'(occ) - CNT_W'(hs) + CNT_W'(inflight_q);
                end else begin
                    push = inflight_q;
                end
            end
            ST_FLUSH: begin
                rd_req     = !fifo_empty;
                drop_cnt_d = drop_cnt_q + CNT_W'(inflight_q);
                if (fifo_empty && !inflight_q) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // No pop while in reset: the word would be lost when inflight clears.
    assign fifo_rd_en = rd_req && !reset;
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            inflight_q <= 1'b0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign busy          = (occ != 2'd0) || inflight_q || (state_q == ST_FLUSH);
    assign words_out     = out_cnt_q;
    assign words_dropped = drop_cnt_q;

endmodule
